// File: rtl/password_sender_if.sv
// Digit bus between a host/lock pair and the password sender.
// master drives the transfer request and lock lights; slave is the sender itself.
interface password_sender_if #(
    parameter int DIGITS = 4
);
    logic                start;
    logic                prog;
    logic [4*DIGITS-1:0] code;
    logic                abort;
    logic                unlockLight;
    logic                errorLight;
    logic [3:0]          digit;
    logic                digitValid;
    logic                setMode;
    logic                busy;
    logic                done;
    logic                pass;
    logic                fail;
    logic                timeout;

    modport master (
        output start, prog, code, abort, unlockLight, errorLight,
        input  digit, digitValid, setMode, busy, done, pass, fail, timeout
    );

    modport slave (
        input  start, prog, code, abort, unlockLight, errorLight,
        output digit, digitValid, setMode, busy, done, pass, fail, timeout
    );
endinterface

// File: rtl/password_sender.sv
// Serial digit transmitter for the password lock: shifts a latched code out MS nibble
// first with an optional inter-digit gap, then (verify mode) waits for the lock's verdict.
module password_sender #(
    parameter int DIGITS  = 4,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 8
) (
    input logic CLK,
    input logic RST,
    password_sender_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int IW = $clog2(DIGITS + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic [2:0]          state;
    logic [4*DIGITS-1:0] shreg;
    logic [IW-1:0]       idx;
    logic [GW-1:0]       gap_cnt;
    logic [TW-1:0]       wait_cnt;
    logic                set_mode;
    logic                pass_r;
    logic                fail_r;
    logic                timeout_r;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            shreg     <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            set_mode  <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else if (state != S_IDLE && bus.abort) begin
            // Abort outranks every other transition, including a lock verdict.
            state     <= S_IDLE;
            set_mode  <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg     <= bus.code;
                        set_mode  <= bus.prog;
                        pass_r    <= 1'b0;
                        fail_r    <= 1'b0;
                        timeout_r <= 1'b0;
                        idx       <= '0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    shreg   <= shreg << 4;
                    idx     <= idx + 1'b1;
                    gap_cnt <= '0;
                    if (idx == IDX_LAST) begin
                        wait_cnt <= '0;
                        state    <= set_mode ? S_DONE : S_WAIT;
                    end else if (GAP > 0) begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_SEND;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                S_WAIT: begin
                    // Error is checked first so a simultaneous pair of lights reports fail.
                    if (bus.errorLight) begin
                        fail_r <= 1'b1;
                        state  <= S_DONE;
                    end else if (bus.unlockLight) begin
                        pass_r <= 1'b1;
                        state  <= S_DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_r <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    set_mode <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: outputs decode registered state only, so there is no latch and no input-to-output path.
    assign bus.digitValid = (state == S_SEND);
    assign bus.digit      = (state == S_SEND) ? shreg[4*DIGITS-1 -: 4] : 4'hF;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.setMode    = set_mode;
    assign bus.pass       = pass_r;
    assign bus.fail       = fail_r;
    assign bus.timeout    = timeout_r;
endmodule

// File: tb/tb_password_sender.sv
// Scoreboarded bench for password_sender: one GAP=0 instance and one GAP=2 instance
// share a clock; digit streams are checked against queued expectations.
module tb_password_sender;
    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        int         cyc;
        logic [3:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    password_sender_if #(.DIGITS(DIGITS)) bus_a ();
    password_sender_if #(.DIGITS(DIGITS)) bus_b ();

    password_sender #(.DIGITS(DIGITS), .GAP(0), .TIMEOUT(TIMEOUT)) dut_a (
        .CLK(clk),
        .RST(rst),
        .bus(bus_a)
    );

    password_sender #(.DIGITS(DIGITS), .GAP(2), .TIMEOUT(TIMEOUT)) dut_b (
        .CLK(clk),
        .RST(rst),
        .bus(bus_b)
    );

    // Scoreboard side: every valid digit must match the next queued digit and cycle.
    always @(negedge clk) begin
        if (bus_a.digitValid) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL digit_a: got %h at cycle %0d, expected no digit", bus_a.digit, cyc);
            end else begin
                ea = exp_a.pop_front();
                if (bus_a.digit !== ea.d || cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL digit_a: got %h at cycle %0d, expected %h at cycle %0d",
                             bus_a.digit, cyc, ea.d, ea.cyc);
                end
            end
        end
        if (bus_b.digitValid) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL digit_b: got %h at cycle %0d, expected no digit", bus_b.digit, cyc);
            end else begin
                eb = exp_b.pop_front();
                if (bus_b.digit !== eb.d || cyc != eb.cyc) begin
                    errors++;
                    $display("FAIL digit_b: got %h at cycle %0d, expected %h at cycle %0d",
                             bus_b.digit, cyc, eb.d, eb.cyc);
                end
            end
        end
    end

    task automatic push(input bit to_b, input logic [15:0] code, input int first,
                        input int step, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = first + i * step;
            e.d   = code[15-4*i -: 4];
            if (to_b) exp_b.push_back(e);
            else      exp_a.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        bus_a.code  = 16'h1234;
        bus_b.code  = 16'h1234;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.digit !== 4'hF || bus_a.digitValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_digit: got %h/%b expected f/0", bus_a.digit, bus_a.digitValid);
        end
        checks++;
        if ({bus_a.setMode, bus_a.busy, bus_a.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus_a.setMode, bus_a.busy, bus_a.done});
        end
        checks++;
        if ({bus_a.pass, bus_a.fail, bus_a.timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus_a.pass, bus_a.fail, bus_a.timeout});
        end
        rst = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_b.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_start: got busy %b expected 00", {bus_a.busy, bus_b.busy});
        end
    endtask

    task automatic test_verify_gap0();
        int c, l, got;
        c = cyc;
        bus_a.code  = 16'h0129;
        bus_a.prog  = 1'b0;
        bus_a.start = 1'b1;
        push(1'b0, 16'h0129, c + 1, 1, DIGITS);
        @(negedge clk);
        bus_a.start = 1'b0;
        l = c + DIGITS;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.done) begin
                got = cyc;
                break;
            end
            bus_a.unlockLight = (cyc == l + 2);
            @(negedge clk);
        end
        bus_a.unlockLight = 1'b0;
        checks++;
        if (got != l + 3) begin
            errors++;
            $display("FAIL verify_done_cycle: got %0d expected %0d", got, l + 3);
        end
        checks++;
        if ({bus_a.pass, bus_a.fail, bus_a.timeout} !== 3'b100) begin
            errors++;
            $display("FAIL verify_flags: got %b expected 100", {bus_a.pass, bus_a.fail, bus_a.timeout});
        end
        @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.pass} !== 2'b01) begin
            errors++;
            $display("FAIL verify_hold: got busy/pass %b expected 01", {bus_a.busy, bus_a.pass});
        end
    endtask

    task automatic test_program_gap2();
        int c, got;
        bit sm_bad;
        c = cyc;
        sm_bad = 1'b0;
        bus_b.code        = 16'h5A3C;
        bus_b.prog        = 1'b1;
        bus_b.start       = 1'b1;
        bus_b.unlockLight = 1'b1;
        bus_b.errorLight  = 1'b1;
        push(1'b1, 16'h5A3C, c + 1, 3, DIGITS);
        @(negedge clk);
        bus_b.start = 1'b0;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_b.busy && !bus_b.setMode) sm_bad = 1'b1;
            if (bus_b.done) begin
                got = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (got != c + 11) begin
            errors++;
            $display("FAIL program_done_cycle: got %0d expected %0d", got, c + 11);
        end
        checks++;
        if ({bus_b.pass, bus_b.fail, bus_b.timeout} !== 3'b000) begin
            errors++;
            $display("FAIL program_flags: got %b expected 000", {bus_b.pass, bus_b.fail, bus_b.timeout});
        end
        checks++;
        if (sm_bad) begin
            errors++;
            $display("FAIL program_setmode: got setMode low while busy expected high");
        end
        bus_b.unlockLight = 1'b0;
        bus_b.errorLight  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_b.setMode, bus_b.busy} !== 2'b00) begin
            errors++;
            $display("FAIL program_idle: got setMode/busy %b expected 00", {bus_b.setMode, bus_b.busy});
        end
    endtask

    task automatic test_timeout_conflict();
        int c, c2, got;
        c = cyc;
        bus_a.code  = 16'hBEEF;
        bus_a.prog  = 1'b0;
        bus_a.start = 1'b1;
        push(1'b0, 16'hBEEF, c + 1, 1, DIGITS);
        @(negedge clk);
        bus_a.start = 1'b0;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.done) begin
                got = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (got != c + DIGITS + 9) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d expected %0d", got, c + DIGITS + 9);
        end
        checks++;
        if ({bus_a.pass, bus_a.fail, bus_a.timeout} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_flags: got %b expected 001", {bus_a.pass, bus_a.fail, bus_a.timeout});
        end
        // Back-to-back: start in the first idle cycle after done, then both lights at once.
        @(negedge clk);
        c2 = cyc;
        bus_a.code  = 16'h4321;
        bus_a.start = 1'b1;
        push(1'b0, 16'h4321, c2 + 1, 1, DIGITS);
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++;
        if ({bus_a.busy, bus_a.timeout} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_back_start: got busy/timeout %b expected 10", {bus_a.busy, bus_a.timeout});
        end
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.done) begin
                got = cyc;
                break;
            end
            bus_a.unlockLight = (cyc == c2 + DIGITS + 1);
            bus_a.errorLight  = (cyc == c2 + DIGITS + 1);
            @(negedge clk);
        end
        bus_a.unlockLight = 1'b0;
        bus_a.errorLight  = 1'b0;
        checks++;
        if (got != c2 + DIGITS + 2) begin
            errors++;
            $display("FAIL conflict_cycle: got %0d expected %0d", got, c2 + DIGITS + 2);
        end
        checks++;
        if ({bus_a.pass, bus_a.fail, bus_a.timeout} !== 3'b010) begin
            errors++;
            $display("FAIL conflict_flags: got %b expected 010", {bus_a.pass, bus_a.fail, bus_a.timeout});
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int c, c2, got;
        c = cyc;
        bus_a.code  = 16'h8642;
        bus_a.prog  = 1'b1;
        bus_a.start = 1'b1;
        push(1'b0, 16'h8642, c + 1, 1, 3);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.setMode !== 1'b1) begin
            errors++;
            $display("FAIL abort_setmode_before: got %b expected 1", bus_a.setMode);
        end
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        checks++;
        if ({bus_a.busy, bus_a.digitValid, bus_a.done, bus_a.setMode} !== 4'b0000 || bus_a.digit !== 4'hF) begin
            errors++;
            $display("FAIL abort_idle: got busy/valid/done/setMode %b digit %h expected 0000 f",
                     {bus_a.busy, bus_a.digitValid, bus_a.done, bus_a.setMode}, bus_a.digit);
        end
        c2 = cyc;
        bus_a.code  = 16'h1357;
        bus_a.start = 1'b1;
        push(1'b0, 16'h1357, c2 + 1, 1, DIGITS);
        @(negedge clk);
        bus_a.start = 1'b0;
        got = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.done) begin
                got = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (got != c2 + DIGITS + 1) begin
            errors++;
            $display("FAIL abort_restart_done: got %0d expected %0d", got, c2 + DIGITS + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int c, dones;
        c = cyc;
        bus_a.code  = 16'h9ABC;
        bus_a.prog  = 1'b0;
        bus_a.start = 1'b1;
        push(1'b0, 16'h9ABC, c + 1, 1, DIGITS);
        @(negedge clk);
        bus_a.start = 1'b0;
        @(negedge clk);
        bus_a.code  = 16'h1111;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.code  = 16'h9ABC;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.digitValid, bus_a.setMode,
             bus_a.pass, bus_a.fail, bus_a.timeout} !== 7'b0 || bus_a.digit !== 4'hF) begin
            errors++;
            $display("FAIL reset_mid_wait: got ctrl %b digit %h expected 0000000 f",
                     {bus_a.busy, bus_a.done, bus_a.digitValid, bus_a.setMode,
                      bus_a.pass, bus_a.fail, bus_a.timeout}, bus_a.digit);
        end
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_a.done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", dones);
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.prog = 1'b0; bus_a.code = '0; bus_a.abort = 1'b0;
        bus_a.unlockLight = 1'b0; bus_a.errorLight = 1'b0;
        bus_b.start = 1'b0; bus_b.prog = 1'b0; bus_b.code = '0; bus_b.abort = 1'b0;
        bus_b.unlockLight = 1'b0; bus_b.errorLight = 1'b0;

        test_reset();
        test_verify_gap0();
        test_program_gap2();
        test_timeout_conflict();
        test_abort();
        test_reset_mid_wait();

        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL digits_missing: got %0d/%0d left expected 0/0", exp_a.size(), exp_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
